// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the crossbar switch allocator: default geometry
// and the per-output FSM state encoding.
package switch_allocator_pkg;

  localparam int DEFAULT_CHANNELS  = 5;
  localparam int DEFAULT_CHNL_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } out_state_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps,
// so the last winner gets lowest priority on the next decision.
module rr_arbiter #(
  parameter int N        = 5,
  parameter int IDX_BITS = 3
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [IDX_BITS-1:0] gnt_idx
);

  logic [IDX_BITS-1:0] idx;
  logic                found;

  // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_BITS'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Crossbar switch allocator: one round-robin arbiter and IDLE/BUSY/DONE FSM
// per tx output, holding each grant for a full 4-phase packet handshake.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int CHANNELS  = DEFAULT_CHANNELS,
  parameter int CHNL_BITS = DEFAULT_CHNL_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           in_req,
  input  logic [CHANNELS*CHNL_BITS-1:0] in_chnl,
  output logic [CHANNELS-1:0]           in_ack,
  output logic [CHANNELS-1:0]           out_req,
  input  logic [CHANNELS-1:0]           out_ack,
  output logic [CHANNELS*CHNL_BITS-1:0] out_sel
);

  logic [CHANNELS*CHNL_BITS-1:0] owner_flat;
  logic [CHANNELS-1:0]           active;
  logic [CHANNELS-1:0]           done_vec;
  logic [CHANNELS-1:0]           owns;

  // An rx that holds any output (BUSY or DONE) may not compete elsewhere.
  always_comb begin
    owns   = '0;
    in_ack = '0;
    for (int o = 0; o < CHANNELS; o++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (owner_flat[o*CHNL_BITS +: CHNL_BITS] == CHNL_BITS'(i)) begin
          if (active[o])   owns[i]   = 1'b1;
          if (done_vec[o]) in_ack[i] = 1'b1;
        end
      end
    end
  end

  assign out_sel = owner_flat;

  for (genvar o = 0; o < CHANNELS; o++) begin : g_out
    out_state_e          state_q, state_d;
    logic [CHNL_BITS-1:0] owner_q, owner_d;
    logic [CHNL_BITS-1:0] ptr_q, ptr_d;
    logic                 out_req_q, out_req_d;
    logic                 done_q, done_d;
    logic [CHANNELS-1:0]  elig;
    logic [CHANNELS-1:0]  gnt;
    logic [CHNL_BITS-1:0] gnt_idx;

    // Out-of-range destinations never match any o, so they are silently ignored.
    always_comb begin
      elig = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        elig[i] = in_req[i] && !owns[i] &&
                  (in_chnl[i*CHNL_BITS +: CHNL_BITS] == CHNL_BITS'(o));
      end
    end

    rr_arbiter #(
      .N        (CHANNELS),
      .IDX_BITS (CHNL_BITS)
    ) u_arb (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
    );

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_d = gnt_idx;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (out_ack[o]) state_d = DONE;
        end
        DONE: begin
          // Pointer moves only when the packet fully retires, so the owner drops to lowest priority.
          if (!in_req[owner_q] && !out_ack[o]) begin
            state_d = IDLE;
            ptr_d   = owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
      out_req_d = (state_d == BUSY);
      done_d    = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= IDLE;
        owner_q   <= '0;
        ptr_q     <= CHNL_BITS'(CHANNELS - 1);
        out_req_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        owner_q   <= owner_d;
        ptr_q     <= ptr_d;
        out_req_q <= out_req_d;
        done_q    <= done_d;
      end
    end

    assign out_req[o]                            = out_req_q;
    assign done_vec[o]                           = done_q;
    assign active[o]                             = (state_q != IDLE);
    assign owner_flat[o*CHNL_BITS +: CHNL_BITS] = owner_q;
  end

endmodule
